gamma_sched: RTL and testbench

Gamma-cycle scheduler and delay-configuration controller for an array of `N_SYN` rising-edge delay units.
- Sequences each gamma cycle: a local reset window, then an active window.
- Drives the shared per-gamma reset into every delay unit.
- Holds each unit's delay value constant for a whole gamma cycle. New values are staged in shadow registers and applied only at a gamma boundary.

---
 rtl/tnn_pkg.sv | 15 +
 rtl/delay_cfg_bank.sv | 82 ++++++++
 rtl/gamma_sched.sv | 112 +++++++++++
 tb/tb_gamma_sched.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tnn_pkg.sv
// Shared types and width helpers for the gamma-cycle scheduler and its delay units.
package tnn_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRST   = 2'd1,
    ACTIVE = 2'd2
  } gamma_state_t;

  // Delay/phase width for a gamma cycle of g clocks.
  function automatic int delay_w(input int g);
    return $clog2(g);
  endfunction

endpackage

// File: rtl/delay_cfg_bank.sv
// Shadow/active delay register banks with write handshake, address check and
// commit tracking; the active bank only changes on a copy strobe while pending.
module delay_cfg_bank
  import tnn_pkg::*;
#(
  parameter int N_SYN = 8,
  parameter int DW    = 7,
  parameter int AW    = 3
) (
  input  logic                      aclk,
  input  logic                      grst,
  input  logic                      cfg_valid_i,
  input  logic [AW-1:0]             cfg_addr_i,
  input  logic [DW-1:0]             cfg_delay_i,
  input  logic                      cfg_commit_i,
  input  logic                      copy_i,
  output logic                      cfg_ready_o,
  output logic                      commit_done_o,
  output logic                      cfg_err_o,
  output logic [N_SYN-1:0][DW-1:0]  delay_o
);

  // One extra bit so the bound N_SYN itself is representable when N_SYN = 2**AW.
  localparam logic [AW:0] N_SYN_L = (AW+1)'(N_SYN);

  logic [N_SYN-1:0][DW-1:0] shadow_q, shadow_d;
  logic [N_SYN-1:0][DW-1:0] active_q, active_d;
  logic                     pending_q, pending_d;
  logic                     commit_done_q, commit_done_d;
  logic                     cfg_err_q, cfg_err_d;
  logic                     accept;
  logic                     in_range;
  logic                     do_copy;

  // Handshake: a write transfers on any cycle where cfg_valid_i & cfg_ready_o;
  // cfg_ready_o drops while a commit is pending so the shadow bank is frozen.
  assign cfg_ready_o = !pending_q;
  assign accept      = cfg_valid_i & !pending_q;
  assign in_range    = {1'b0, cfg_addr_i} < N_SYN_L;
  assign do_copy     = pending_q & copy_i;

  always_comb begin
    shadow_d      = shadow_q;
    active_d      = active_q;
    pending_d     = pending_q;
    commit_done_d = 1'b0;
    cfg_err_d     = accept & !in_range;
    if (accept && in_range) begin
      for (int i = 0; i < N_SYN; i++) begin
        if (cfg_addr_i == AW'(i)) shadow_d[i] = cfg_delay_i;
      end
    end
    if (do_copy) begin
      active_d      = shadow_q;
      pending_d     = 1'b0;
      commit_done_d = 1'b1;
    end else if (cfg_commit_i) begin
      pending_d = 1'b1;
    end
  end

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      shadow_q      <= '0;
      active_q      <= '0;
      pending_q     <= 1'b0;
      commit_done_q <= 1'b0;
      cfg_err_q     <= 1'b0;
    end else begin
      shadow_q      <= shadow_d;
      active_q      <= active_d;
      pending_q     <= pending_d;
      commit_done_q <= commit_done_d;
      cfg_err_q     <= cfg_err_d;
    end
  end

  assign commit_done_o = commit_done_q;
  assign cfg_err_o     = cfg_err_q;
  assign delay_o       = active_q;

endmodule

// File: rtl/gamma_sched.sv
// Gamma-cycle scheduler: reset window then active window per gamma cycle, with
// delay configuration applied only at gamma boundaries (or immediately when idle).
module gamma_sched
  import tnn_pkg::*;
#(
  parameter  int GAMMA_CYCLE_WIDTH = 128,
  parameter  int N_SYN             = 8,
  parameter  int RST_CYCLES        = 1,
  parameter  int DW                = delay_w(GAMMA_CYCLE_WIDTH),
  localparam int AW                = (N_SYN > 1) ? $clog2(N_SYN) : 1
) (
  input  logic                      aclk,
  input  logic                      grst,
  input  logic                      run_i,
  input  logic                      cfg_valid_i,
  output logic                      cfg_ready_o,
  input  logic [AW-1:0]             cfg_addr_i,
  input  logic [DW-1:0]             cfg_delay_i,
  input  logic                      cfg_commit_i,
  output logic                      commit_done_o,
  output logic                      cfg_err_o,
  output logic                      gamma_rst_o,
  output logic                      gamma_start_o,
  output logic [DW-1:0]             phase_o,
  output logic                      busy_o,
  output logic [N_SYN-1:0][DW-1:0]  delay_out_o,
  output gamma_state_t              state_o
);

  localparam logic [DW-1:0] LAST_PH  = DW'(GAMMA_CYCLE_WIDTH - 1);
  localparam logic [DW-1:0] RST_LAST = DW'(RST_CYCLES - 1);

  gamma_state_t  state_q;
  logic [DW-1:0] phase_q;
  logic          gamma_rst_q;
  logic          gamma_start_q;
  logic          copy;

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      gamma_rst_q   <= 1'b1;
      gamma_start_q <= 1'b0;
    end else begin
      gamma_start_q <= 1'b0;
      case (state_q)
        IDLE: begin
          phase_q     <= '0;
          gamma_rst_q <= 1'b1;
          if (run_i) begin
            state_q       <= GRST;
            gamma_start_q <= 1'b1;
          end
        end
        GRST: begin
          phase_q <= phase_q + 1'b1;
          if (phase_q == RST_LAST) begin
            state_q     <= ACTIVE;
            gamma_rst_q <= 1'b0;
          end
        end
        ACTIVE: begin
          phase_q <= phase_q + 1'b1;
          // run_i is only sampled at the last phase, so a gamma cycle always completes.
          if (phase_q == LAST_PH) begin
            gamma_rst_q <= 1'b1;
            if (run_i) begin
              state_q       <= GRST;
              gamma_start_q <= 1'b1;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q     <= IDLE;
          phase_q     <= '0;
          gamma_rst_q <= 1'b1;
        end
      endcase
    end
  end

  // Delays may change only while the units are held in gamma reset.
  assign copy = (state_q == IDLE) || ((state_q == ACTIVE) && (phase_q == LAST_PH));

  delay_cfg_bank #(
    .N_SYN (N_SYN),
    .DW    (DW),
    .AW    (AW)
  ) u_bank (
    .aclk          (aclk),
    .grst          (grst),
    .cfg_valid_i   (cfg_valid_i),
    .cfg_addr_i    (cfg_addr_i),
    .cfg_delay_i   (cfg_delay_i),
    .cfg_commit_i  (cfg_commit_i),
    .copy_i        (copy),
    .cfg_ready_o   (cfg_ready_o),
    .commit_done_o (commit_done_o),
    .cfg_err_o     (cfg_err_o),
    .delay_o       (delay_out_o)
  );

  assign gamma_rst_o   = gamma_rst_q;
  assign gamma_start_o = gamma_start_q;
  assign phase_o       = phase_q;
  assign busy_o        = (state_q != IDLE);
  assign state_o       = state_q;

endmodule

// File: tb/tb_gamma_sched.sv
// Directed bench for gamma_sched: reset, idle commit, continuous run, mid-gamma
// commit, stop, out-of-range write and reset with a pending commit.
module tb_gamma_sched;
  import tnn_pkg::*;

  localparam int G  = 16;
  localparam int RC = 2;
  localparam int NS = 8;
  localparam int NE = 5;
  localparam int DW = 4;

  logic aclk = 1'b0;
  logic grst;
  always #5 aclk = ~aclk;

  logic               run, cfg_valid, cfg_ready, cfg_commit, commit_done, cfg_err;
  logic [2:0]         cfg_addr;
  logic [DW-1:0]      cfg_delay, phase;
  logic               gamma_rst, gamma_start, busy;
  logic [NS-1:0][DW-1:0] delay_out;
  gamma_state_t       state;

  // Addr 9 does not fit the 3-bit address of an 8-unit array, so the
  // out-of-range path is exercised on a 5-unit instance (addr 7).
  logic               e_run, e_valid, e_ready, e_commit, e_commit_done, e_err;
  logic [2:0]         e_addr;
  logic [DW-1:0]      e_delay, e_phase;
  logic               e_gamma_rst, e_gamma_start, e_busy;
  logic [NE-1:0][DW-1:0] e_delay_out;
  gamma_state_t       e_state;

  gamma_sched #(.GAMMA_CYCLE_WIDTH(G), .N_SYN(NS), .RST_CYCLES(RC)) dut (
    .aclk(aclk), .grst(grst), .run_i(run), .cfg_valid_i(cfg_valid),
    .cfg_ready_o(cfg_ready), .cfg_addr_i(cfg_addr), .cfg_delay_i(cfg_delay),
    .cfg_commit_i(cfg_commit), .commit_done_o(commit_done), .cfg_err_o(cfg_err),
    .gamma_rst_o(gamma_rst), .gamma_start_o(gamma_start), .phase_o(phase),
    .busy_o(busy), .delay_out_o(delay_out), .state_o(state)
  );

  gamma_sched #(.GAMMA_CYCLE_WIDTH(G), .N_SYN(NE), .RST_CYCLES(RC)) dut_e (
    .aclk(aclk), .grst(grst), .run_i(e_run), .cfg_valid_i(e_valid),
    .cfg_ready_o(e_ready), .cfg_addr_i(e_addr), .cfg_delay_i(e_delay),
    .cfg_commit_i(e_commit), .commit_done_o(e_commit_done), .cfg_err_o(e_err),
    .gamma_rst_o(e_gamma_rst), .gamma_start_o(e_gamma_start), .phase_o(e_phase),
    .busy_o(e_busy), .delay_out_o(e_delay_out), .state_o(e_state)
  );

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  initial begin
    int starts;
    grst = 1'b1; run = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_delay = '0; cfg_commit = 1'b0;
    e_run = 1'b0; e_valid = 1'b0; e_addr = '0; e_delay = '0; e_commit = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_gamma_rst", gamma_rst, 1);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_delay", delay_out, 0);
    chk("rst_start", gamma_start, 0);
    chk("rst_done", commit_done, 0);
    chk("rst_err", cfg_err, 0);
    chk("rst_state", state, IDLE);
    grst = 1'b0;
    tick();

    // Idle commit: addr 3 = 5
    cfg_valid = 1'b1; cfg_addr = 3'd3; cfg_delay = 4'd5;
    tick();
    chk("idle_wr_err", cfg_err, 0);
    chk("idle_wr_ready", cfg_ready, 1);
    cfg_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    chk("idle_pend_ready", cfg_ready, 0);
    chk("idle_pend_done", commit_done, 0);
    chk("idle_pend_delay", delay_out, 0);
    cfg_commit = 1'b0;
    tick();
    chk("idle_copy_done", commit_done, 1);
    chk("idle_copy_delay", delay_out, 32'h0000_5000);
    chk("idle_copy_ready", cfg_ready, 1);
    chk("idle_copy_state", state, IDLE);
    tick();
    chk("idle_done_clr", commit_done, 0);

    // Continuous run, with a write+commit at phase 7
    run = 1'b1;
    tick();
    chk("run_state", state, GRST);
    chk("run_phase0", phase, 0);
    chk("run_start", gamma_start, 1);
    chk("run_grst", gamma_rst, 1);
    chk("run_busy", busy, 1);
    for (int k = 1; k < G; k++) begin
      tick();
      chk("c1_phase", phase, k);
      chk("c1_gamma_rst", gamma_rst, (k < RC) ? 1 : 0);
      chk("c1_start", gamma_start, 0);
      if (k == 7) begin
        cfg_valid = 1'b1; cfg_addr = 3'd0; cfg_delay = 4'd9; cfg_commit = 1'b1;
      end
      if (k == 8) begin
        chk("mid_ready", cfg_ready, 0);
        cfg_addr = 3'd1; cfg_delay = 4'hA; cfg_commit = 1'b0;
      end
      if (k > 8) begin
        chk("mid_delay_hold", delay_out, 32'h0000_5000);
        chk("mid_done_low", commit_done, 0);
      end
    end
    tick();
    chk("c2_phase0", phase, 0);
    chk("c2_start", gamma_start, 1);
    chk("c2_grst", gamma_rst, 1);
    chk("c2_done", commit_done, 1);
    chk("c2_delay", delay_out, 32'h0000_5009);
    chk("c2_ready", cfg_ready, 1);
    cfg_valid = 1'b0; cfg_commit = 1'b1;
    tick();
    chk("c2_pend_ready", cfg_ready, 0);
    chk("c2_start_clr", gamma_start, 0);
    cfg_commit = 1'b0;

    // Stop: run drops at phase 9, cycle still completes
    for (int k = 2; k < G; k++) begin
      tick();
      if (k == 9) run = 1'b0;
      chk("c2_phase", phase, k);
      chk("c2_gamma_rst", gamma_rst, (k < RC) ? 1 : 0);
      chk("c2_busy", busy, 1);
    end
    tick();
    chk("stop_state", state, IDLE);
    chk("stop_phase", phase, 0);
    chk("stop_grst", gamma_rst, 1);
    chk("stop_busy", busy, 0);
    chk("stop_start", gamma_start, 0);
    chk("stop_done", commit_done, 1);
    chk("stop_delay", delay_out, 32'h0000_5009);
    starts = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (gamma_start) starts++;
    end
    chk("stop_no_start", starts, 0);
    chk("stop_busy_low", busy, 0);

    // Out-of-range write on the 5-unit instance, then an in-range one at the top address
    e_valid = 1'b1; e_addr = 3'd7; e_delay = 4'd3;
    tick();
    chk("err_pulse", e_err, 1);
    e_addr = 3'd4; e_delay = 4'd6;
    tick();
    chk("err_clr", e_err, 0);
    e_valid = 1'b0; e_commit = 1'b1;
    tick();
    e_commit = 1'b0;
    tick();
    chk("err_done", e_commit_done, 1);
    chk("err_delay", e_delay_out, 20'h6_0000);

    // Pending commit discarded by grst at phase 4
    cfg_valid = 1'b1; cfg_addr = 3'd2; cfg_delay = 4'd7;
    tick();
    cfg_valid = 1'b0; run = 1'b1;
    tick();
    chk("gr_phase0", phase, 0);
    tick(); tick(); tick();
    chk("gr_phase3", phase, 3);
    cfg_commit = 1'b1;
    tick();
    chk("gr_phase4", phase, 4);
    chk("gr_pend", cfg_ready, 0);
    cfg_commit = 1'b0; run = 1'b0;
    #2 grst = 1'b1;
    #1;
    chk("gr_delay", delay_out, 0);
    chk("gr_ready", cfg_ready, 1);
    chk("gr_phase", phase, 0);
    chk("gr_busy", busy, 0);
    chk("gr_gamma_rst", gamma_rst, 1);
    #3 grst = 1'b0;
    tick(); tick(); tick();
    chk("gr_no_done", commit_done, 0);
    chk("gr_delay_after", delay_out, 0);
    chk("gr_state", state, IDLE);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
